// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: FSM state codes, the opcodes it
// reacts to directly, and default timing parameters.
package exec_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        IN_WAIT = 2'd2,
        HALTED  = 2'd3
    } seq_state_t;

    localparam logic [5:0] OP_IN   = 6'b011000;
    localparam logic [5:0] OP_HALT = 6'b011011;

    localparam int unsigned DEFAULT_MD_TIMEOUT  = 64;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // The in opcode owns its own stall, so a Halt flag raised alongside it is not a halt.
    function automatic logic is_halt_op(input logic [5:0] op, input logic halt_flag);
        return (op == OP_HALT) || (halt_flag && (op != OP_IN));
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Connection bundle between the control decoder / mult-div unit / user switches
// and the execution sequencer that gates their write enables.
interface exec_sequencer_if;

    logic [5:0]  opcode;
    logic        Halt;
    logic        WriteR;
    logic        WriteM;
    logic        WriteO;
    logic        WriteLH;
    logic        md_done;
    logic        in_valid;
    logic        resume;

    logic        PcEn;
    logic        RegWrEn;
    logic        MemWrEn;
    logic        OutLoad;
    logic        LHWrite;
    logic        md_start;
    logic        InAck;
    logic [1:0]  state;
    logic        md_err;
    logic [31:0] retired;

    modport master (
        output opcode, Halt, WriteR, WriteM, WriteO, WriteLH, md_done, in_valid, resume,
        input  PcEn, RegWrEn, MemWrEn, OutLoad, LHWrite, md_start, InAck, state, md_err, retired
    );

    modport slave (
        input  opcode, Halt, WriteR, WriteM, WriteO, WriteLH, md_done, in_valid, resume,
        output PcEn, RegWrEn, MemWrEn, OutLoad, LHWrite, md_start, InAck, state, md_err, retired
    );

endinterface

// File: rtl/exec_sequencer_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level input followed by a registered
// rising-edge detector; rise is a single-cycle pulse SYNC_STAGES+1 clocks after the change.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= synced;
            rise   <= synced & ~last_q;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: gates decoder write enables and the PC update, stalling for
// the mult/div unit, user input and halt, and counts retired (PC-advancing) cycles.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT  = DEFAULT_MD_TIMEOUT,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                    clock,
    input  logic                    reset,
    exec_sequencer_if.slave         bus
);

    localparam int unsigned TIMER_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MD_TIMEOUT - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               md_err_q;
    logic               err_set;
    logic [31:0]        retired_q;

    logic pc_en;
    logic reg_wr;
    logic mem_wr;
    logic out_load;
    logic lh_write;
    logic md_start;
    logic in_ack;

    logic in_rise;
    logic resume_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (bus.in_valid),
        .rise     (in_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_resume_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (bus.resume),
        .rise     (resume_rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            timer_q   <= '0;
            md_err_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            md_err_q <= md_err_q | err_set;
            if (pc_en) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        err_set  = 1'b0;
        pc_en    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        out_load = 1'b0;
        lh_write = 1'b0;
        md_start = 1'b0;
        in_ack   = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.opcode == OP_IN) begin
                    state_d = IN_WAIT;
                end else if (is_halt_op(bus.opcode, bus.Halt)) begin
                    state_d = HALTED;
                end else if (bus.WriteLH) begin
                    md_start = 1'b1;
                    timer_d  = '0;
                    state_d  = MD_WAIT;
                end else begin
                    pc_en    = 1'b1;
                    reg_wr   = bus.WriteR;
                    mem_wr   = bus.WriteM;
                    out_load = bus.WriteO;
                end
            end
            // A done pulse on the last permitted cycle still completes the operation.
            MD_WAIT: begin
                if (bus.md_done) begin
                    lh_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = RUN;
                end else if (timer_q == TIMER_LAST) begin
                    err_set = 1'b1;
                    state_d = HALTED;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            IN_WAIT: begin
                if (in_rise) begin
                    reg_wr  = 1'b1;
                    in_ack  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (resume_rise) begin
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset is asynchronous, so the combinational enables are silenced directly.
        if (reset) begin
            pc_en    = 1'b0;
            reg_wr   = 1'b0;
            mem_wr   = 1'b0;
            out_load = 1'b0;
            lh_write = 1'b0;
            md_start = 1'b0;
            in_ack   = 1'b0;
            err_set  = 1'b0;
        end
    end

    assign bus.PcEn     = pc_en;
    assign bus.RegWrEn  = reg_wr;
    assign bus.MemWrEn  = mem_wr;
    assign bus.OutLoad  = out_load;
    assign bus.LHWrite  = lh_write;
    assign bus.md_start = md_start;
    assign bus.InAck    = in_ack;
    assign bus.state    = state_q;
    assign bus.md_err   = md_err_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a per-cycle behavioural model built from input
// histories and wait counters, plus hand-computed literal checks at key cycles.
module tb_exec_sequencer;

    localparam int TO = 64;
    localparam int SS = 2;

    localparam logic [5:0] C_ADD  = 6'b100000;
    localparam logic [5:0] C_MULT = 6'b000001;
    localparam logic [5:0] C_IN   = 6'b011000;
    localparam logic [5:0] C_HALT = 6'b011011;
    localparam logic [5:0] C_MISC = 6'b000111;

    logic clock;
    logic reset;

    exec_sequencer_if bus();

    exec_sequencer #(.MD_TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 waiting on mult/div, 2 waiting on input, 3 halted
    int          m_mode;
    int          m_mdcyc;
    logic        m_err;
    logic [31:0] m_ret;
    logic        iv_hist [0:7];
    logic        rs_hist [0:7];
    logic        e_pc, e_rw, e_mw, e_ol, e_lh, e_st, e_ack;
    int          nxt;
    logic        seen_in, seen_res;

    always @(negedge clock) begin
        if (bus.md_start === 1'b1) n_start++;
    end

    always @(negedge clock) begin
        e_pc = 0; e_rw = 0; e_mw = 0; e_ol = 0; e_lh = 0; e_st = 0; e_ack = 0;
        if (reset) begin
            m_mode = 0; m_mdcyc = 0; m_err = 0; m_ret = '0;
            for (int i = 0; i < 8; i++) begin
                iv_hist[i] = 0;
                rs_hist[i] = 0;
            end
            nxt = 0;
        end else begin
            // An edge becomes usable SYNC_STAGES+1 clocks after the level change is sampled.
            seen_in  = iv_hist[SS] && !iv_hist[SS+1];
            seen_res = rs_hist[SS] && !rs_hist[SS+1];
            nxt = m_mode;
            if (m_mode == 0) begin
                if (bus.opcode == C_IN) nxt = 2;
                else if (bus.opcode == C_HALT || bus.Halt) nxt = 3;
                else if (bus.WriteLH) begin e_st = 1; nxt = 1; m_mdcyc = 0; end
                else begin
                    e_pc = 1; e_rw = bus.WriteR; e_mw = bus.WriteM; e_ol = bus.WriteO;
                end
            end else if (m_mode == 1) begin
                m_mdcyc++;
                if (bus.md_done) begin e_lh = 1; e_pc = 1; nxt = 0; end
                else if (m_mdcyc == TO) nxt = 3;
            end else if (m_mode == 2) begin
                if (seen_in) begin e_rw = 1; e_ack = 1; e_pc = 1; nxt = 0; end
            end else begin
                if (seen_res) begin e_pc = 1; nxt = 0; end
            end
        end

        chk("PcEn",     bus.PcEn,     e_pc);
        chk("RegWrEn",  bus.RegWrEn,  e_rw);
        chk("MemWrEn",  bus.MemWrEn,  e_mw);
        chk("OutLoad",  bus.OutLoad,  e_ol);
        chk("LHWrite",  bus.LHWrite,  e_lh);
        chk("md_start", bus.md_start, e_st);
        chk("InAck",    bus.InAck,    e_ack);
        chk("state",    bus.state,    m_mode);
        chk("md_err",   bus.md_err,   m_err);
        chk("retired",  bus.retired,  m_ret);

        if (!reset) begin
            if (m_mode == 1 && nxt == 3) m_err = 1;
            if (e_pc) m_ret = m_ret + 32'd1;
            m_mode = nxt;
            for (int i = 7; i > 0; i--) begin
                iv_hist[i] = iv_hist[i-1];
                rs_hist[i] = rs_hist[i-1];
            end
            iv_hist[0] = bus.in_valid;
            rs_hist[0] = bus.resume;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic h, input logic wr,
                         input logic wm, input logic wo, input logic wlh);
        bus.opcode = op; bus.Halt = h; bus.WriteR = wr;
        bus.WriteM = wm; bus.WriteO = wo; bus.WriteLH = wlh;
    endtask

    initial begin
        reset = 1'b1;
        bus.md_done = 0; bus.in_valid = 0; bus.resume = 0;
        instr(C_ADD, 0, 1, 0, 0, 0);
        wait_neg();
        chk("rst_pcen", bus.PcEn, 0);
        chk("rst_regwr", bus.RegWrEn, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_retired", bus.retired, 0);
        repeat (3) step();
        reset = 1'b0;

        // five plain register-writing instructions
        repeat (5) begin
            wait_neg();
            chk("run_regwr", bus.RegWrEn, 1);
            step();
        end

        // mult/div completing 10 cycles after start
        instr(C_MULT, 0, 0, 0, 0, 1);
        wait_neg();
        chk("retired_5", bus.retired, 5);
        chk("md_start_on", bus.md_start, 1);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        repeat (9) step();
        bus.md_done = 1;
        wait_neg();
        chk("md_done_lh", bus.LHWrite, 1);
        chk("md_done_pc", bus.PcEn, 1);
        step();
        bus.md_done = 0;
        chk("md_start_count", n_start, 1);
        chk("md_err_clear", bus.md_err, 0);
        chk("retired_6", bus.retired, 6);

        // store then output instruction, with a stray md_done in RUN
        instr(C_ADD, 0, 0, 1, 0, 0);
        wait_neg();
        chk("store_memwr", bus.MemWrEn, 1);
        step();
        instr(C_ADD, 0, 0, 0, 1, 0);
        bus.md_done = 1;
        wait_neg();
        chk("out_load", bus.OutLoad, 1);
        chk("stray_done_lh", bus.LHWrite, 0);
        step();
        bus.md_done = 0;

        // md_done on the last permitted wait cycle wins over the timeout
        instr(C_MULT, 0, 0, 0, 0, 1);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        repeat (TO - 1) step();
        bus.md_done = 1;
        wait_neg();
        chk("edge_done_lh", bus.LHWrite, 1);
        step();
        bus.md_done = 0;
        chk("edge_done_noerr", bus.md_err, 0);
        chk("edge_done_state", bus.state, 0);

        // timeout with no md_done
        instr(C_MULT, 0, 0, 0, 0, 1);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        repeat (TO - 1) step();
        wait_neg();
        chk("to_last_state", bus.state, 1);
        step();
        chk("to_state", bus.state, 3);
        chk("to_err", bus.md_err, 1);
        bus.resume = 1;
        step(); step();
        wait_neg();
        chk("resume_early", bus.PcEn, 0);
        step();
        wait_neg();
        chk("resume_pc", bus.PcEn, 1);
        step();
        chk("resume_state", bus.state, 0);
        chk("resume_err_sticky", bus.md_err, 1);
        bus.resume = 0;

        // input edge during RUN is discarded; then a real input wait
        bus.in_valid = 1;
        repeat (2) step();
        bus.in_valid = 0;
        repeat (6) step();
        instr(C_IN, 0, 1, 0, 0, 0);
        wait_neg();
        chk("in_run_regwr", bus.RegWrEn, 0);
        chk("in_run_pc", bus.PcEn, 0);
        step();
        repeat (7) step();
        chk("in_wait_state", bus.state, 2);
        bus.in_valid = 1;
        step(); step();
        wait_neg();
        chk("in_ack_early", bus.InAck, 0);
        step();
        wait_neg();
        chk("in_ack", bus.InAck, 1);
        chk("in_regwr", bus.RegWrEn, 1);
        chk("in_pc", bus.PcEn, 1);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        wait_neg();
        chk("in_back_run", bus.state, 0);
        step();
        bus.in_valid = 0;

        // halt opcode, 100 idle cycles, then resume
        instr(C_HALT, 0, 1, 0, 0, 0);
        wait_neg();
        chk("halt_pc", bus.PcEn, 0);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        repeat (100) step();
        chk("halt_state", bus.state, 3);
        bus.resume = 1;
        step(); step();
        wait_neg();
        chk("halt_resume_early", bus.PcEn, 0);
        step();
        wait_neg();
        chk("halt_resume_pc", bus.PcEn, 1);
        step();
        chk("halt_resume_state", bus.state, 0);
        bus.resume = 0;

        // Halt flag on an ordinary opcode
        instr(C_MISC, 1, 1, 0, 0, 0);
        wait_neg();
        chk("hflag_regwr", bus.RegWrEn, 0);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        chk("hflag_state", bus.state, 3);
        repeat (3) step();
        bus.resume = 1;
        repeat (3) step();
        wait_neg();
        chk("hflag_resume_pc", bus.PcEn, 1);
        step();
        bus.resume = 0;

        // reset in the middle of an input wait
        instr(C_IN, 0, 1, 0, 0, 0);
        step();
        step(); step();
        chk("mid_in_state", bus.state, 2);
        bus.in_valid = 1;
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_state", bus.state, 0);
        chk("mid_rst_regwr", bus.RegWrEn, 0);
        chk("mid_rst_ack", bus.InAck, 0);
        chk("mid_rst_retired", bus.retired, 0);
        step();
        instr(C_ADD, 0, 1, 0, 0, 0);
        reset = 1'b0;
        repeat (6) step();
        wait_neg();
        chk("post_rst_pc", bus.PcEn, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter MD_TIMEOUT, default 64: maximum cycles spent waiting for md_done before an error is flagged.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for the in_valid and resume inputs.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  6  current instruction opcode, same encoding as the control decoder.
REQ-006 Halt, WriteR, WriteM, WriteO, WriteLH  input  1 each  raw control-decoder outputs for the current instruction.
REQ-007 md_done  input  1  mult/div unit result ready, 1-cycle pulse.
REQ-008 in_valid, resume  input  1 each  asynchronous user switches, level.
REQ-009 PcEn  output  1  PC update enable.
REQ-010 RegWrEn, MemWrEn, OutLoad, LHWrite  output  1 each  gated write enables for the register file, data memory, output latch and LO/HI.
REQ-011 md_start  output  1  1-cycle start pulse to the mult/div unit.
REQ-012 InAck  output  1  1-cycle acknowledge of consumed input.
REQ-013 state  output  2  current FSM state code.
REQ-014 md_err  output  1  sticky mult/div timeout flag.
REQ-015 retired  output  32  count of cycles in which PcEn=1.

Function
REQ-016 States SHALL be RUN=0, MD_WAIT=1, IN_WAIT=2, HALTED=3.
REQ-017 In RUN with no stalling opcode: PcEn=1; RegWrEn=WriteR; MemWrEn=WriteM; OutLoad=WriteO; LHWrite=0.
REQ-018 RUN with WriteLH=1: md_start=1 for that cycle only, PcEn=0, all write enables 0; next state MD_WAIT; timer cleared to 0.
REQ-019 MD_WAIT: PcEn=0; timer increments each cycle; md_done=1 -> LHWrite=1, PcEn=1 that cycle, next RUN.
REQ-020 MD_WAIT with timer reaching MD_TIMEOUT-1 and no md_done: md_err set to 1, next HALTED, PcEn stays 0.
REQ-021 md_done and timeout in the same cycle: md_done wins; no error.
REQ-022 RUN with opcode 6'b011000 (in): PcEn=0, RegWrEn=0, next IN_WAIT.
REQ-023 IN_WAIT: on a synchronized rising edge of in_valid -> RegWrEn=1, InAck=1, PcEn=1 for exactly that cycle, next RUN.
REQ-024 RUN with opcode 6'b011011 (halt) -> PcEn=0, next HALTED; any other opcode with Halt=1 (other than in) is also treated as halt.
REQ-025 HALTED: all enables 0; a synchronized rising edge of resume -> PcEn=1 for one cycle, next RUN; md_err is not cleared.
REQ-026 Edges of in_valid or resume outside IN_WAIT or HALTED are discarded, not queued.
REQ-027 md_done outside MD_WAIT is ignored.
REQ-028 retired increments by 1 in every cycle with PcEn=1 and wraps from 2^32-1 to 0.
REQ-029 Edge-detected input latency: an input change is visible after SYNC_STAGES+1 clocks.

Reset
REQ-030 On reset assertion, the block SHALL asynchronously set: state=RUN, timer=0, md_err=0, retired=0, synchronizer and edge flops=0.
REQ-031 While reset is high, PcEn, RegWrEn, MemWrEn, OutLoad, LHWrite, md_start and InAck SHALL be forced to 0.
REQ-032 Reset mid-operation (MD_WAIT, IN_WAIT or HALTED) SHALL abandon the operation with no write enable emitted.

Structure
REQ-033 A shared package SHALL hold the state encoding, the OP_IN=6'b011000 and OP_HALT=6'b011011 constants, and the MD_TIMEOUT default.
REQ-034 A sub-module edge_sync (SYNC_STAGES flop synchronizer plus rising-edge detector) SHALL be instantiated twice, once for in_valid and once for resume.

Verification
REQ-035 Reset, then 5 cycles of opcode add with WriteR=1 -> RegWrEn=1 and PcEn=1 every cycle; retired=5.
REQ-036 WriteLH=1, md_done pulsed 10 cycles later -> exactly one md_start; PcEn=0 for 10 cycles; LHWrite=PcEn=1 on the done cycle; md_err=0.
REQ-037 WriteLH=1 with no md_done -> md_err=1 and state=HALTED after 64 MD_WAIT cycles; resume edge -> RUN; md_err stays 1.
REQ-038 opcode in, in_valid raised after 7 cycles -> single-cycle RegWrEn/InAck/PcEn 3 clocks after the raise; a pulse given earlier, in RUN, is ignored.
REQ-039 opcode halt -> HALTED, PcEn=0 for 100 cycles; resume edge -> one PcEn pulse; reset asserted mid-IN_WAIT -> state=RUN, no enables.
